// File: rtl/ras_spill_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : ras_spill_responder_if
// Brief    : RAS spill/fill memory port between the RAS controller and the
//            memory-side responder.
// Revision : 1.0 - initial release
// ============================================================================
interface ras_spill_responder_if #(
    parameter int W = 32
) ();
    logic          mem_rd;
    logic          mem_wr;
    logic [31:0]   mem_addr;
    logic [W-1:0]  mem_din;
    logic          mem_rdy;
    logic [W-1:0]  mem_dout;
    logic          mem_dout_valid;

    modport master (
        output mem_rd, mem_wr, mem_addr, mem_din,
        input  mem_rdy, mem_dout, mem_dout_valid
    );

    modport slave (
        input  mem_rd, mem_wr, mem_addr, mem_din,
        output mem_rdy, mem_dout, mem_dout_valid
    );
endinterface
`default_nettype wire

// File: rtl/ras_spill_responder.sv
`default_nettype none
// ============================================================================
// Module   : ras_spill_responder
// Brief    : Memory-side responder for the RAS spill/fill port: posted-write
//            FIFO in front of a word array, fixed-latency reads, error flags.
// Revision : 1.0 - initial release
// ============================================================================
module ras_spill_responder #(
    parameter int W           = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int READ_LAT    = 2,
    parameter int WBUF_DEPTH  = 4
) (
    input  wire logic                           clk,
    input  wire logic                           rst,
    ras_spill_responder_if.slave                bus,
    output logic [1:0]                          err,
    input  wire logic                           clr_err,
    output logic [$clog2(WBUF_DEPTH):0]         wbuf_count,
    output logic [$clog2(DEPTH_WORDS):0]        hi_water
);
    localparam int c_AW = $clog2(DEPTH_WORDS);
    localparam int c_CW = $clog2(WBUF_DEPTH) + 1;
    localparam int c_PW = $clog2(WBUF_DEPTH);
    localparam int c_LW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [c_CW-1:0] c_FULL     = c_CW'(WBUF_DEPTH);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
    localparam logic [c_PW-1:0] c_PTR_ONE  = c_PW'(1);
    localparam logic [c_LW-1:0] c_LAT_INIT = c_LW'(READ_LAT - 1);
    localparam logic [c_LW-1:0] c_LAT_ONE  = c_LW'(1);
    localparam logic [c_AW:0]   c_HI_ONE   = (c_AW+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DRAIN   = 2'd1,
        S_RD_WAIT = 2'd2,
        S_RD_RESP = 2'd3
    } state_t;

    state_t            r_state;
    logic [c_LW-1:0]   r_lat;
    logic [c_AW-1:0]   r_rd_idx;
    logic              r_rd_err;
    logic [W-1:0]      r_dout;
    logic              r_dout_valid;

    logic [W-1:0]      r_mem      [DEPTH_WORDS];
    logic [c_AW-1:0]   r_fifo_idx [WBUF_DEPTH];
    logic [W-1:0]      r_fifo_dat [WBUF_DEPTH];
    logic [c_PW-1:0]   r_wptr;
    logic [c_PW-1:0]   r_rptr;
    logic [c_CW-1:0]   r_count;
    logic [c_AW:0]     r_hi;
    logic [1:0]        r_err;

    logic              w_rdy;
    logic              w_accept;
    logic              w_both;
    logic              w_addr_err;
    logic [c_AW-1:0]   w_idx;
    logic              w_push;
    logic              w_read;
    logic              w_drain;
    logic [c_AW-1:0]   w_drain_idx;
    logic [W-1:0]      w_drain_dat;
    logic [c_AW:0]     w_drain_top;
    logic [1:0]        w_err_set;

    // rdy is gated by rst so nothing is accepted while reset is held
    assign w_rdy       = (r_state == S_IDLE) && (r_count < c_FULL) && !rst;
    assign w_accept    = w_rdy && (bus.mem_rd || bus.mem_wr);
    assign w_both      = bus.mem_rd && bus.mem_wr;
    assign w_addr_err  = (bus.mem_addr[1:0] != 2'b00) || (bus.mem_addr[31:c_AW+2] != '0);
    assign w_idx       = bus.mem_addr[c_AW+1:2];
    assign w_push      = w_accept && bus.mem_wr && !bus.mem_rd && !w_addr_err;
    assign w_read      = w_accept && bus.mem_rd && !bus.mem_wr;
    assign w_drain     = (r_count != '0);
    assign w_drain_idx = r_fifo_idx[r_rptr];
    assign w_drain_dat = r_fifo_dat[r_rptr];
    assign w_drain_top = {1'b0, w_drain_idx} + c_HI_ONE;
    assign w_err_set   = {w_accept && w_both, w_accept && !w_both && w_addr_err};

    // Storage is not reset; only pointers and occupancy are.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_idx[r_wptr] <= w_idx;
            r_fifo_dat[r_wptr] <= bus.mem_din;
        end
        if (w_drain) begin
            r_mem[w_drain_idx] <= w_drain_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_hi    <= '0;
            r_err   <= '0;
        end else begin
            if (w_push)  r_wptr <= r_wptr + c_PTR_ONE;
            if (w_drain) r_rptr <= r_rptr + c_PTR_ONE;
            case ({w_push, w_drain})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_drain && (w_drain_top > r_hi)) r_hi <= w_drain_top;
            // a newly raised flag wins over a simultaneous clear
            r_err <= (clr_err ? 2'b00 : r_err) | w_err_set;
        end
    end

    // Reads wait in DRAIN until the FIFO is empty, so they see all prior writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_lat        <= '0;
            r_rd_idx     <= '0;
            r_rd_err     <= 1'b0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_dout_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_read) begin
                        r_rd_idx <= w_idx;
                        r_rd_err <= w_addr_err;
                        r_lat    <= c_LAT_INIT;
                        r_state  <= w_drain ? S_DRAIN : S_RD_WAIT;
                    end
                end
                S_DRAIN: begin
                    if (r_count == '0) begin
                        r_lat   <= c_LAT_INIT;
                        r_state <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (r_lat == '0) r_state <= S_RD_RESP;
                    else             r_lat   <= r_lat - c_LAT_ONE;
                end
                S_RD_RESP: begin
                    r_dout       <= r_rd_err ? '0 : r_mem[r_rd_idx];
                    r_dout_valid <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_rdy        = w_rdy;
    assign bus.mem_dout       = r_dout;
    assign bus.mem_dout_valid = r_dout_valid;
    assign err                = r_err;
    assign wbuf_count         = r_count;
    assign hi_water           = r_hi;
endmodule
`default_nettype wire

// File: tb/tb_ras_spill_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ras_spill_responder
// Brief    : Scoreboard bench for ras_spill_responder with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ras_spill_responder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr_err = 1'b0;
    logic [1:0] err;
    logic [2:0] wbuf_count;
    logic [8:0] hi_water;

    ras_spill_responder_if #(.W(32)) bus ();

    ras_spill_responder #(
        .W(32), .DEPTH_WORDS(256), .READ_LAT(2), .WBUF_DEPTH(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .err        (err),
        .clr_err    (clr_err),
        .wbuf_count (wbuf_count),
        .hi_water   (hi_water)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        int          lat;
        int          acc;
    } exp_t;
    exp_t sb[$];

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: every response strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.mem_dout_valid) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_valid: got dout %0h expected no response (t=%0t)",
                         bus.mem_dout, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rd_data", bus.mem_dout, e.data);
                check("rd_latency", cyc - e.acc, e.lat);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic req(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, output int acc);
        int n = 0;
        bus.mem_rd = rd; bus.mem_wr = wr; bus.mem_addr = a; bus.mem_din = d;
        while (!bus.mem_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.mem_rdy) begin
            n_total++;
            $display("FAIL accept_timeout: got no accept for addr %0h expected accept", a);
            acc = -1;
            bus.mem_rd = 1'b0; bus.mem_wr = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            acc = cyc;
            bus.mem_rd = 1'b0; bus.mem_wr = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic rd_exp(input logic [31:0] a, input logic [31:0] data, input int lat);
        int acc;
        exp_t e;
        req(1'b1, 1'b0, a, 32'h0, acc);
        e.data = data; e.lat = lat; e.acc = acc;
        if (acc >= 0) sb.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_total++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL resp_timeout: got %0d pending expected 0", sb.size());
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int prev;
        bus.mem_rd = 1'b0; bus.mem_wr = 1'b0; bus.mem_addr = '0; bus.mem_din = '0;
        repeat (3) @(negedge clk);
        check("rdy_in_reset", bus.mem_rdy, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_rdy", bus.mem_rdy, 1);
        check("rst_err", err, 0);
        check("rst_wbuf", wbuf_count, 0);
        check("rst_hi", hi_water, 0);
        check("rst_dout", bus.mem_dout, 0);

        // Write then read at once: one pending entry adds a cycle
        req(1'b0, 1'b1, 32'h10, 32'hA5A5_0001, acc);
        check("wbuf_after_wr", wbuf_count, 1);
        check("hi_before_drain", hi_water, 0);
        rd_exp(32'h10, 32'hA5A5_0001, 4);
        check("rdy_in_drain", bus.mem_rdy, 0);
        check("wbuf_drained", wbuf_count, 0);
        wait_idle();
        check("hi_after_0x10", hi_water, 5);

        // Back-to-back writes stream through with occupancy one
        prev = -1;
        for (int i = 0; i < 4; i++) begin
            req(1'b0, 1'b1, 32'h20 + 32'(4*i), 32'h1111_1111 * (i+1), acc);
            check("stream_rdy", bus.mem_rdy, 1);
            check("stream_wbuf", wbuf_count, 1);
            if (i > 0) check("stream_b2b", acc - prev, 1);
            prev = acc;
        end
        rd_exp(32'h20, 32'h1111_1111, 4);
        check("rdy_blocked", bus.mem_rdy, 0);
        for (int i = 0; i < 5; i++)
            req(1'b0, 1'b1, 32'h30 + 32'(4*i), 32'h3000_0000 + 32'(i), acc);
        rd_exp(32'h30, 32'h3000_0000, 4);
        for (int i = 1; i < 5; i++)
            rd_exp(32'h30 + 32'(4*i), 32'h3000_0000 + 32'(i), 3);
        rd_exp(32'h2C, 32'h4444_4444, 3);
        wait_idle();
        check("hi_after_stream", hi_water, 17);

        // Address errors
        rd_exp(32'h402, 32'h0, 3);
        wait_idle();
        check("err_rd_addr", err, 2'b01);
        clr_err = 1'b1;
        req(1'b0, 1'b1, 32'h400, 32'hDEAD_BEEF, acc);
        clr_err = 1'b0;
        check("err_clr_vs_set", err, 2'b01);
        check("err_wr_dropped", wbuf_count, 0);
        @(negedge clk);
        check("hi_unchanged", hi_water, 17);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("err_cleared", err, 2'b00);

        // Read and write together
        req(1'b0, 1'b1, 32'h8, 32'hCAFE_0002, acc);
        req(1'b1, 1'b1, 32'h8, 32'h0000_0BAD, acc);
        check("err_proto", err, 2'b10);
        check("proto_wbuf", wbuf_count, 0);
        check("proto_idle", bus.mem_rdy, 1);
        rd_exp(32'h8, 32'hCAFE_0002, 3);
        wait_idle();

        // Reset while a read waits for its latency
        req(1'b0, 1'b1, 32'h50, 32'h5555_0005, acc);
        @(negedge clk);
        req(1'b1, 1'b0, 32'h50, 32'h0, acc);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_rdy", bus.mem_rdy, 0);
        check("mid_rst_valid", bus.mem_dout_valid, 0);
        check("mid_rst_dout", bus.mem_dout, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_hi", hi_water, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        // Reset discards a buffered write
        req(1'b0, 1'b1, 32'h50, 32'h6666_6666, acc);
        rst = 1'b1;
        @(negedge clk);
        check("rst_wbuf_cleared", wbuf_count, 0);
        rst = 1'b0;
        @(negedge clk);
        rd_exp(32'h50, 32'h5555_0005, 3);
        wait_idle();
        check("hi_after_rst", hi_water, 0);

        repeat (4) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
